// File: rtl/serial_incrementer.sv
// Bit-serial incrementer: S = A + 1, one bit per enabled clock, LSB first.
// Optional saturation clamps an all-ones operand to all ones instead of wrapping.
module serial_incrementer #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] S,
  output logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is taken on an enabled edge while not busy (IDLE or DONE);
  // done pulses for one enabled cycle and S/carry_out stay stable until the next take.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_accept;
  logic             w_sum;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;

  assign w_accept     = enable && start && ((r_state == IDLE) || (r_state == DONE));
  assign w_sum        = r_shift[0] ^ r_carry;
  assign w_carry_next = r_shift[0] & r_carry;
  assign w_shifted    = {w_sum, r_shift[WIDTH-1:1]};
  assign w_last       = (r_cnt == LAST);

  always_comb begin
    w_state_next = r_state;
    if (enable) begin
      unique case (r_state)
        IDLE:    if (start) w_state_next = RUN;
        RUN:     if (w_last) w_state_next = DONE;
        DONE:    w_state_next = start ? RUN : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_shift <= A;
      r_carry <= 1'b1;
      r_cnt   <= '0;
    end else if (enable && (r_state == RUN)) begin
      r_shift <= w_shifted;
      r_carry <= w_carry_next;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // The final carry is set only when every operand bit was one.
        r_s    <= (SATURATE && w_carry_next) ? {WIDTH{1'b1}} : w_shifted;
        r_cout <= w_carry_next;
      end
    end
  end

  assign S           = r_s;
  assign carry_out   = r_cout;
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_incrementer.sv
// Directed bench for serial_incrementer: wrapping and saturating instances side by side,
// expected results queued at start and checked at the done pulse.
module tb_serial_incrementer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         start;
  logic [W-1:0] a;

  logic [W-1:0] s0, s1;
  logic         c0, c1, b0, b1, d0, d1;
  logic [1:0]   st0, st1;

  logic [W:0] exp_q[$];
  logic [W:0] exp_sat_q[$];

  int tests;
  int failed;
  int n;
  int stall_n;
  logic seen_done;

  serial_incrementer #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .A(a),
    .S(s0), .carry_out(c0), .busy(b0), .done(d0), .o_dbg_state(st0)
  );

  serial_incrementer #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .A(a),
    .S(s1), .carry_out(c1), .busy(b1), .done(d1), .o_dbg_state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_s"}, {s1, s0}, '0);
    chk({tag, "_cout"}, {c1, c0}, '0);
    chk({tag, "_busy"}, {b1, b0}, '0);
    chk({tag, "_done"}, {d1, d0}, '0);
  endtask

  task automatic push_exp(input logic [W-1:0] val);
    logic [W:0] sum;
    sum = {1'b0, val} + 1'b1;
    exp_q.push_back(sum);
    exp_sat_q.push_back(sum[W] ? {1'b1, {W{1'b1}}} : sum);
  endtask

  // Drive start with operand for one edge; the expected result is queued here.
  task automatic start_op(input logic [W-1:0] val);
    start = 1'b1;
    a     = val;
    push_exp(val);
    tick();
    start = 1'b0;
    a     = 'x;
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    while (d0 !== 1'b1 && cnt < max) begin
      tick();
      cnt++;
    end
    chk("done_seen", {d1, d0}, 2'b11);
  endtask

  task automatic check_result(input string tag);
    logic [W:0] e0, e1;
    if (exp_q.size() == 0 || exp_sat_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e0 = exp_q.pop_front();
      e1 = exp_sat_q.pop_front();
      chk({tag, "_wrap"}, {c0, s0}, e0);
      chk({tag, "_sat"}, {c1, s1}, e1);
      chk({tag, "_busy_low"}, {b1, b0}, '0);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] val);
    start_op(val);
    chk({tag, "_busy"}, {b1, b0}, 2'b11);
    wait_done(20, n);
    chk({tag, "_latency"}, n, W);
    check_result(tag);
    tick();
    chk({tag, "_done_drop"}, {d1, d0}, '0);
    chk({tag, "_hold"}, s0, (val + 1'b1) & 4'hf);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    a      = '0;

    tick();
    tick();
    rst = 1'b0;
    check_idle_zero("reset");
    chk("reset_state", st0, 2'd0);

    for (int i = 0; i < 10; i++) tick();
    check_idle_zero("idle");

    run_op("basic", 4'b0101);
    run_op("wrap", 4'b1111);
    run_op("zero", 4'b0000);
    run_op("six", 4'b0110);

    // Stall three edges mid-run while a start pulse is offered and must be ignored.
    start_op(4'b0111);
    tick();
    enable = 1'b0;
    start  = 1'b1;
    a      = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_busy", {b1, b0}, 2'b11);
    chk("stall_no_done", {d1, d0}, '0);
    enable = 1'b1;
    tick();
    start = 1'b0;
    a     = 'x;
    wait_done(20, stall_n);
    chk("stall_latency", 1 + 3 + 1 + stall_n, W + 3);
    check_result("stall");
    tick();
    chk("stall_no_extra", {b1, b0}, '0);

    // Done held while enable is low.
    start_op(4'b0010);
    wait_done(20, n);
    check_result("hold_pre");
    enable = 1'b0;
    tick();
    tick();
    chk("done_hold", {d1, d0}, 2'b11);
    enable = 1'b1;

    // Back-to-back: next start is offered in the DONE cycle.
    start_op(4'b1001);
    chk("b2b_busy", {b1, b0}, 2'b11);
    chk("b2b_done_low", {d1, d0}, '0);
    chk("b2b_s_held", s0, 4'b0011);
    wait_done(20, n);
    chk("b2b_latency", n, W);
    check_result("b2b");
    tick();

    // Reset on the second run edge aborts with no done pulse.
    start = 1'b1;
    a     = 4'b0011;
    tick();
    start = 1'b0;
    a     = 'x;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("abort");
    chk("abort_state", st0, 2'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d0 === 1'b1 || d1 === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 1'b0);
    run_op("after_abort", 4'b0011);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)));
    end

    chk("queue_drained", exp_q.size() + exp_sat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
